// File: rtl/spi_slave_shiftreg.sv
// SPI slave with double-buffered transmit word and parallel receive word, oversampled on clk.
// Define SPI_SLAVE_SHIFTREG_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module spi_slave_shiftreg #(
   parameter int N    = 8,
   parameter int CPOL = 0,
   parameter int CPHA = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         spi_clk,
   input  logic         spi_cs_n,
   input  logic         din,
   output logic         dout,
   input  logic [N-1:0] tx_data,
   input  logic         tx_load,
   output logic         tx_ready,
   output logic [N-1:0] rx_data,
   output logic         rx_valid,
   output logic         tx_underrun
);

   localparam int   CW          = $clog2(N);
   localparam logic IDLE_SCLK   = (CPOL != 0);
   localparam logic SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic           r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic           r_cs_meta, r_cs_sync, r_cs_prev;
   logic           r_din_meta, r_din_sync;

   logic [CW-1:0]  r_cnt;
   logic [N-2:0]   r_rx_shift;
   logic [N-1:0]   r_tx_shift;
   logic [N-1:0]   r_buf;
   logic           r_buf_full;
   logic           r_ur_pending;

   logic           w_sclk_rise, w_sclk_fall;
   logic           w_sample_edge, w_shift_edge;
   logic           w_cs_fall;
   logic           w_enter, w_leave;
   logic           w_in_word, w_do_sample, w_do_shift, w_word_done, w_transfer;
   logic           w_accept;
   logic [N-1:0]   w_rx_next;
   logic [N-1:0]   w_tx_shifted;
   logic           w_tx_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sclk_meta <= IDLE_SCLK;
         r_sclk_sync <= IDLE_SCLK;
         r_sclk_prev <= IDLE_SCLK;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_din_meta  <= 1'b0;
         r_din_sync  <= 1'b0;
      end else begin
         r_sclk_meta <= spi_clk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_cs_meta   <= spi_cs_n;
         r_cs_sync   <= r_cs_meta;
         r_cs_prev   <= r_cs_sync;
         r_din_meta  <= din;
         r_din_sync  <= r_din_meta;
      end
   end

   assign w_sclk_rise   = r_sclk_sync & ~r_sclk_prev;
   assign w_sclk_fall   = ~r_sclk_sync & r_sclk_prev;
   assign w_sample_edge = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
   assign w_shift_edge  = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
   assign w_cs_fall     = r_cs_prev & ~r_cs_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_enter      = 1'b0;
      w_leave      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_next = ST_ACTIVE;
               w_enter      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (r_cs_sync) begin
               w_state_next = ST_IDLE;
               w_leave      = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A shift edge at count 0 is skipped: the fresh word's first bit is already on dout.
   assign w_in_word   = (r_state == ST_ACTIVE) & ~r_cs_sync;
   assign w_do_sample = w_in_word & w_sample_edge;
   assign w_word_done = w_do_sample & (r_cnt == CW'(N - 1));
   assign w_do_shift  = w_in_word & w_shift_edge & (r_cnt != '0);
   assign w_transfer  = w_enter | w_word_done;
   assign w_accept    = tx_load & ~r_buf_full;

`ifdef SPI_SLAVE_SHIFTREG_LSB_FIRST_EN
   assign w_rx_next    = {r_din_sync, r_rx_shift};
   assign w_tx_shifted = {1'b0, r_tx_shift[N-1:1]};
   assign w_tx_bit     = r_tx_shift[0];
`else
   assign w_rx_next    = {r_rx_shift, r_din_sync};
   assign w_tx_shifted = {r_tx_shift[N-2:0], 1'b0};
   assign w_tx_bit     = r_tx_shift[N-1];
`endif

   // An empty-buffer transfer at a word boundary only reports underrun once the next word really starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_rx_shift   <= '0;
         r_tx_shift   <= '0;
         r_buf        <= '0;
         r_buf_full   <= 1'b0;
         r_ur_pending <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         tx_underrun  <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;

         if (w_leave) begin
            r_cnt        <= '0;
            r_tx_shift   <= '0;
            r_ur_pending <= 1'b0;
         end else if (w_transfer) begin
            r_cnt      <= '0;
            r_tx_shift <= r_buf_full ? r_buf : '0;
            if (w_enter) begin
               tx_underrun  <= ~r_buf_full;
               r_ur_pending <= 1'b0;
            end else begin
               r_ur_pending <= ~r_buf_full;
            end
         end else begin
            if (w_do_sample) begin
               r_cnt <= r_cnt + 1'b1;
               if (r_ur_pending) begin
                  tx_underrun  <= 1'b1;
                  r_ur_pending <= 1'b0;
               end
            end
            if (w_do_shift) begin
               r_tx_shift <= w_tx_shifted;
            end
         end

         if (w_do_sample) begin
`ifdef SPI_SLAVE_SHIFTREG_LSB_FIRST_EN
            r_rx_shift <= w_rx_next[N-1:1];
`else
            r_rx_shift <= w_rx_next[N-2:0];
`endif
         end
         if (w_word_done) begin
            rx_data  <= w_rx_next;
            rx_valid <= 1'b1;
         end

         // A load coinciding with a transfer refills the buffer for the following word.
         if (w_transfer) begin
            r_buf_full <= w_accept;
         end else if (w_accept) begin
            r_buf_full <= 1'b1;
         end
         if (w_accept) begin
            r_buf <= tx_data;
         end
      end
   end

   assign tx_ready = ~r_buf_full;
   assign dout     = (r_state == ST_ACTIVE) & w_tx_bit;

endmodule

// File: tb/tb_spi_slave_shiftreg.sv
// Bench for spi_slave_shiftreg (N=8, mode 0): table-driven frames plus hand sequences, rx scoreboard.
// Honours SPI_SLAVE_SHIFTREG_LSB_FIRST_EN for master bit order.
module tb_spi_slave_shiftreg;

   localparam int N    = 8;
   localparam int HALF = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         spi_clk;
   logic         spi_cs_n;
   logic         din;
   logic         dout;
   logic [N-1:0] tx_data;
   logic         tx_load;
   logic         tx_ready;
   logic [N-1:0] rx_data;
   logic         rx_valid;
   logic         tx_underrun;

   int           tests = 0;
   int           fails = 0;
   int           rx_pulses = 0;
   int           ur_pulses = 0;
   logic [N-1:0] sb_q[$];
   logic [N-1:0] sb_exp;
   logic [N-1:0] last_rx;

   typedef struct {
      logic         do_load;
      logic [N-1:0] tx_word;
      logic [N-1:0] mosi;
      logic [N-1:0] exp_miso;
      int           exp_ur;
   } vec_t;

   vec_t vecs[5];

   spi_slave_shiftreg #(.N(N), .CPOL(0), .CPHA(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_clk    (spi_clk),
      .spi_cs_n   (spi_cs_n),
      .din        (din),
      .dout       (dout),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_pulses++;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required none", rx_data);
         end else begin
            sb_exp = sb_q.pop_front();
            check("rx_data", {24'd0, rx_data}, {24'd0, sb_exp});
            $display("[TB] rx word %02h (expected %02h)", rx_data, sb_exp);
         end
      end
      if (tx_underrun === 1'b1) ur_pulses++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int bit_idx(input int k);
`ifdef SPI_SLAVE_SHIFTREG_LSB_FIRST_EN
      return k;
`else
      return N - 1 - k;
`endif
   endfunction

   task automatic load_word(input logic [N-1:0] d);
      int guard = 0;
      while (tx_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (tx_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL load_wait: got tx_ready=%b, required 1 within 100 cycles", tx_ready);
      end else begin
         tx_data = d;
         tx_load = 1'b1;
         @(negedge clk);
         tx_load = 1'b0;
         check("ready_drop", {31'd0, tx_ready}, 32'd0);
      end
   endtask

   // Mode-0 master: data set during low phase, MISO captured as spi_clk rises.
   task automatic xfer(input logic [N-1:0] mosi, input int nbits, output logic [N-1:0] miso);
      int idx;
      miso = '0;
      for (int k = 0; k < nbits; k++) begin
         idx = bit_idx(k);
         din = mosi[idx];
         wait_clk(HALF);
         spi_clk = 1'b1;
         miso[idx] = dout;
         wait_clk(HALF);
         spi_clk = 1'b0;
      end
      wait_clk(HALF);
   endtask

   task automatic run_frame(input logic [N-1:0] mosi, output logic [N-1:0] miso);
      spi_cs_n = 1'b0;
      wait_clk(4);
      xfer(mosi, N, miso);
      spi_cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic check_reset_outputs();
      check("rst_dout",     {31'd0, dout},        32'd0);
      check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
      check("rst_rx_data",  {24'd0, rx_data},     32'd0);
      check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
      check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
   endtask

   initial begin
      logic [N-1:0] miso;
      logic [N-1:0] m1;
      logic [N-1:0] m2;
      int           r0;
      int           u0;

      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
      vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1};
      vecs[2] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 0};
      vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
      vecs[4] = '{1'b1, 8'h01, 8'h80, 8'h01, 0};

      reset    = 1'b1;
      spi_clk  = 1'b0;
      spi_cs_n = 1'b1;
      din      = 1'b0;
      tx_load  = 1'b0;
      tx_data  = '0;
      last_rx  = '0;
      wait_clk(3);
      check_reset_outputs();
      reset = 1'b0;
      wait_clk(4);

      for (int i = 0; i < 5; i++) begin
         r0 = rx_pulses;
         u0 = ur_pulses;
         if (vecs[i].do_load) load_word(vecs[i].tx_word);
         sb_q.push_back(vecs[i].mosi);
         last_rx = vecs[i].mosi;
         run_frame(vecs[i].mosi, miso);
         check("vec_miso", {24'd0, miso}, {24'd0, vecs[i].exp_miso});
         check("vec_rx_pulses", rx_pulses - r0, 1);
         check("vec_underrun", ur_pulses - u0, vecs[i].exp_ur);
         check("vec_ready", {31'd0, tx_ready}, 32'd1);
         check("vec_idle_dout", {31'd0, dout}, 32'd0);
         $display("[TB] vec %0d: mosi=%02h miso=%02h underruns=%0d", i, vecs[i].mosi, miso, ur_pulses - u0);
      end

      // load while buffer full is ignored
      load_word(8'hC6);
      tx_data = 8'h77;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
      check("ready_held", {31'd0, tx_ready}, 32'd0);
      sb_q.push_back(8'h0F);
      last_rx = 8'h0F;
      run_frame(8'h0F, miso);
      check("ignored_load_miso", {24'd0, miso}, 32'hC6);
      $display("[TB] ignored load: miso=%02h", miso);

      // two back-to-back words with CS held low
      r0 = rx_pulses;
      u0 = ur_pulses;
      load_word(8'h11);
      sb_q.push_back(8'h96);
      sb_q.push_back(8'h69);
      spi_cs_n = 1'b0;
      wait_clk(4);
      load_word(8'h22);
      xfer(8'h96, N, m1);
      xfer(8'h69, N, m2);
      spi_cs_n = 1'b1;
      wait_clk(8);
      last_rx = 8'h69;
      check("b2b_miso1", {24'd0, m1}, 32'h11);
      check("b2b_miso2", {24'd0, m2}, 32'h22);
      check("b2b_rx_pulses", rx_pulses - r0, 2);
      check("b2b_underrun", ur_pulses - u0, 0);
      $display("[TB] back-to-back: miso=%02h,%02h", m1, m2);

      // CS abort after 5 bits; buffered word must survive
      r0 = rx_pulses;
      spi_cs_n = 1'b0;
      wait_clk(4);
      load_word(8'h99);
      xfer(8'h80, 5, miso);
      spi_cs_n = 1'b1;
      wait_clk(8);
      check("abort_rx_pulses", rx_pulses - r0, 0);
      check("abort_rx_keep", {24'd0, rx_data}, {24'd0, last_rx});
      check("abort_buf_kept", {31'd0, tx_ready}, 32'd0);
      sb_q.push_back(8'h42);
      last_rx = 8'h42;
      run_frame(8'h42, miso);
      check("abort_next_miso", {24'd0, miso}, 32'h99);
      $display("[TB] abort then frame 42: miso=%02h", miso);

      // reset after 3 bits, then a fresh frame
      spi_cs_n = 1'b0;
      wait_clk(4);
      xfer(8'hFF, 3, miso);
      reset = 1'b1;
      wait_clk(2);
      check_reset_outputs();
      spi_cs_n = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(4);
      load_word(8'h3C);
      sb_q.push_back(8'h5A);
      run_frame(8'h5A, miso);
      check("post_rst_miso", {24'd0, miso}, 32'h3C);
      check("post_rst_rx", {24'd0, rx_data}, 32'h5A);
      $display("[TB] reset mid-frame then 5A: miso=%02h rx=%02h", miso, rx_data);

      check("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_slave_shiftreg.md
SPI_SLAVE_SHIFTREG -- requirements
Module: spi_slave_shiftreg

Interface
REQ-001 SHALL have parameter N, default 8: shift word width in bits, N >= 2.
REQ-002 SHALL have parameter CPOL, default 0: spi_clk idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port spi_clk  input  1  SPI serial clock, asynchronous to clk, sampled as data.
REQ-007 SHALL have port spi_cs_n  input  1  chip select, active low, asynchronous.
REQ-008 SHALL have port din  input  1  serial data in (MOSI), asynchronous.
REQ-009 SHALL have port dout  output  1  serial data out (MISO).
REQ-010 SHALL have port tx_data  input  N  word to transmit.
REQ-011 SHALL have port tx_load  input  1  write strobe for tx_data, accepted only when tx_ready=1.
REQ-012 SHALL have port tx_ready  output  1  transmit buffer empty.
REQ-013 SHALL have port rx_data  output  N  last complete received word.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse when a word starts with an empty buffer.

Function
REQ-016 spi_clk, spi_cs_n and din SHALL each pass through a 2-flop synchronizer before use; edges SHALL be detected on synchronized spi_clk against a registered copy.
REQ-017 Sample edge SHALL be rising when CPOL==CPHA, else falling; shift edge SHALL be the opposite edge.
REQ-018 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized spi_cs_n falling; ACTIVE->IDLE on synchronized spi_cs_n high.
REQ-019 On entering ACTIVE and at each word boundary, the tx buffer SHALL transfer into the shift register, bit counter SHALL clear to 0, tx_ready SHALL rise.
REQ-020 If the buffer is empty at a transfer, the shift register SHALL load all zeros and tx_underrun SHALL pulse for one cycle.
REQ-021 tx_load with tx_ready=1 SHALL capture tx_data and drop tx_ready the next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-022 tx_load in the same cycle as a transfer SHALL go to the buffer after the transfer (next word), not to the current word.
REQ-023 On each sample edge in ACTIVE, synchronized din SHALL shift in and the counter SHALL increment.
REQ-024 On each shift edge in ACTIVE (CPHA=0) or on every shift edge but the first (CPHA=1), dout SHALL advance to the next bit.
REQ-025 On the Nth sample edge, rx_data SHALL update and rx_valid SHALL pulse high for exactly one clk, one cycle after that edge is detected; the counter SHALL wrap to 0 and REQ-019 SHALL apply.
REQ-026 Deassertion of spi_cs_n mid-word SHALL discard the partial word: no rx_valid, counter 0, rx_data unchanged, tx buffer unchanged.
REQ-027 dout SHALL be 0 in IDLE.
REQ-028 Correct operation SHALL require spi_clk high and low phases each >= 4 clk periods.

Reset
REQ-029 While reset=1 at a clk edge: state IDLE, counter 0, shift register 0, buffer empty, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, dout=0, synchronizers to idle levels (spi_clk=CPOL, spi_cs_n=1).
REQ-030 Reset mid-frame SHALL abort the word; after release the block SHALL wait for a fresh spi_cs_n falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_SHIFTREG_LSB_FIRST_EN defined: bits shift in and out LSB first; undefined: MSB first.

Verification
REQ-032 N=8, mode 0, load 0xA5, master sends 0x3C -> dout bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
REQ-033 Two back-to-back words, CS held, buffer 0x11 then 0x22 loaded in time -> dout 0x11 then 0x22; rx_valid pulses twice; no tx_underrun.
REQ-034 No tx_load, master sends 0xFF -> dout all zeros; tx_underrun pulses once; rx_data=0xFF.
REQ-035 CS deasserted after 5 bits of 0x80 -> no rx_valid; rx_data keeps prior value; next full frame 0x42 received correctly.
REQ-036 Reset asserted after 3 bits, then full frame 0x5A -> rx_data=0x5A, outputs at reset values during reset.
REQ-037 LSB_FIRST_EN defined, load 0x01, receive 0x80 sent LSB first -> dout first bit 1; rx_data=0x80.
